// File: rtl/handshake_reg_slice.sv
// Valid/ready register slice with bypass, forward, skid and fully-registered modes.
// Up to STAGES identical slices are chained inside one instance; occ counts held beats.
module handshake_reg_slice #(
  parameter int WIDTH  = 8,
  parameter int MODE   = 3,
  parameter int STAGES = 1,
  parameter int OCCW   = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_valid,
  input  logic [WIDTH-1:0] m_data,
  output logic             m_ready,
  output logic             s_valid,
  output logic [WIDTH-1:0] s_data,
  input  logic             s_ready,
  output logic [OCCW-1:0]  occ
);

  // Handshake: a beat moves across a link at a rising edge where valid and ready
  // are both high; a raised valid and its data hold until that happens.
  typedef enum logic       { PASS, SKID }        skid_state_e;
  typedef enum logic [1:0] { EMPTY, BUSY, FULL } full_state_e;

  logic            in_acc;
  logic            out_acc;
  logic [OCCW-1:0] occ_q;
  logic [OCCW-1:0] occ_d;

  generate
    if (MODE == 0) begin : g_bypass
      assign s_valid = m_valid;
      assign s_data  = m_data;
      assign m_ready = s_ready;

    end else if (MODE == 1) begin : g_fwd
      logic [STAGES:0]              vld;
      logic [STAGES:0]              rdy;
      logic [STAGES:0][WIDTH-1:0]   dat;
      logic [STAGES-1:0]            valid_q;
      logic [STAGES-1:0]            valid_d;
      logic [STAGES-1:0][WIDTH-1:0] data_q;
      logic [STAGES-1:0][WIDTH-1:0] data_d;

      always_comb begin
        vld     = '0;
        rdy     = '0;
        dat     = '0;
        valid_d = valid_q;
        data_d  = data_q;
        vld[0]      = m_valid;
        dat[0]      = m_data;
        rdy[STAGES] = s_ready;
        for (int k = 0; k < STAGES; k++) begin
          vld[k+1] = valid_q[k];
          dat[k+1] = data_q[k];
        end
        // Ready ripples back through every stage; reset forces it low.
        for (int k = STAGES - 1; k >= 0; k--) begin
          rdy[k] = (~valid_q[k] | rdy[k+1]) & ~rst;
        end
        for (int k = 0; k < STAGES; k++) begin
          if (vld[k] && rdy[k]) begin
            valid_d[k] = 1'b1;
            data_d[k]  = dat[k];
          end else if (rdy[k+1]) begin
            valid_d[k] = 1'b0;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign m_ready = rdy[0];
      assign s_valid = vld[STAGES];
      assign s_data  = dat[STAGES];

    end else if (MODE == 2) begin : g_skid
      logic [STAGES:0]              vld;
      logic [STAGES:0]              rdy;
      logic [STAGES:0][WIDTH-1:0]   dat;
      skid_state_e                  st_q [STAGES];
      skid_state_e                  st_d [STAGES];
      logic [STAGES-1:0]            ready_q;
      logic [STAGES-1:0]            ready_d;
      logic [STAGES-1:0][WIDTH-1:0] skid_q;
      logic [STAGES-1:0][WIDTH-1:0] skid_d;

      always_comb begin
        vld     = '0;
        rdy     = '0;
        dat     = '0;
        ready_d = ready_q;
        skid_d  = skid_q;
        for (int k = 0; k < STAGES; k++) st_d[k] = st_q[k];
        vld[0]      = m_valid;
        dat[0]      = m_data;
        rdy[STAGES] = s_ready;
        for (int k = 0; k < STAGES; k++) rdy[k] = ready_q[k];
        for (int k = 0; k < STAGES; k++) begin
          // Incoming valid only passes through once ready is up, so nothing
          // is offered downstream that upstream has not handed over.
          vld[k+1] = (st_q[k] == SKID) | (vld[k] & ready_q[k]);
          dat[k+1] = (st_q[k] == SKID) ? skid_q[k] : dat[k];
          case (st_q[k])
            PASS: if (vld[k] && ready_q[k] && !rdy[k+1]) begin
              st_d[k]   = SKID;
              skid_d[k] = dat[k];
            end
            SKID: if (rdy[k+1]) st_d[k] = PASS;
          endcase
          ready_d[k] = (st_d[k] == PASS);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ready_q <= '0;
          skid_q  <= '0;
          for (int k = 0; k < STAGES; k++) st_q[k] <= PASS;
        end else begin
          ready_q <= ready_d;
          skid_q  <= skid_d;
          for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
        end
      end

      assign m_ready = rdy[0];
      assign s_valid = vld[STAGES];
      assign s_data  = dat[STAGES];

    end else begin : g_full
      logic [STAGES:0]              vld;
      logic [STAGES:0]              rdy;
      logic [STAGES:0][WIDTH-1:0]   dat;
      full_state_e                  st_q [STAGES];
      full_state_e                  st_d [STAGES];
      logic [STAGES-1:0]            valid_q;
      logic [STAGES-1:0]            valid_d;
      logic [STAGES-1:0]            ready_q;
      logic [STAGES-1:0]            ready_d;
      logic [STAGES-1:0][WIDTH-1:0] main_q;
      logic [STAGES-1:0][WIDTH-1:0] main_d;
      logic [STAGES-1:0][WIDTH-1:0] skid_q;
      logic [STAGES-1:0][WIDTH-1:0] skid_d;
      logic                         acc;

      always_comb begin
        vld     = '0;
        rdy     = '0;
        dat     = '0;
        valid_d = valid_q;
        ready_d = ready_q;
        main_d  = main_q;
        skid_d  = skid_q;
        acc     = 1'b0;
        for (int k = 0; k < STAGES; k++) st_d[k] = st_q[k];
        vld[0]      = m_valid;
        dat[0]      = m_data;
        rdy[STAGES] = s_ready;
        for (int k = 0; k < STAGES; k++) begin
          rdy[k]   = ready_q[k];
          vld[k+1] = valid_q[k];
          dat[k+1] = main_q[k];
        end
        for (int k = 0; k < STAGES; k++) begin
          acc = vld[k] & ready_q[k];
          case (st_q[k])
            EMPTY: if (acc) begin
              st_d[k]   = BUSY;
              main_d[k] = dat[k];
            end
            BUSY: begin
              if (acc && rdy[k+1]) begin
                main_d[k] = dat[k];
              end else if (acc) begin
                st_d[k]   = FULL;
                skid_d[k] = dat[k];
              end else if (rdy[k+1]) begin
                st_d[k] = EMPTY;
              end
            end
            FULL: if (rdy[k+1]) begin
              st_d[k]   = BUSY;
              main_d[k] = skid_q[k];
            end
            default: st_d[k] = EMPTY;
          endcase
          valid_d[k] = (st_d[k] != EMPTY);
          ready_d[k] = (st_d[k] != FULL);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          ready_q <= '0;
          main_q  <= '0;
          skid_q  <= '0;
          for (int k = 0; k < STAGES; k++) st_q[k] <= EMPTY;
        end else begin
          valid_q <= valid_d;
          ready_q <= ready_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
        end
      end

      assign m_ready = rdy[0];
      assign s_valid = vld[STAGES];
      assign s_data  = dat[STAGES];
    end
  endgenerate

  // Held beats = accepted minus delivered; in bypass both sides always match.
  assign in_acc  = m_valid & m_ready;
  assign out_acc = s_valid & s_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_acc && !out_acc) begin
      occ_d = occ_q + OCCW'(1);
    end else if (!in_acc && out_acc) begin
      occ_d = occ_q - OCCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occ = occ_q;

endmodule

// File: tb/tb_handshake_reg_slice.sv
// Bench for handshake_reg_slice: one instance per mode (bypass, forward x3,
// skid x2, full x1), directed scenarios followed by randomised scoreboard runs.
module tb_handshake_reg_slice;

  logic       clk;
  logic       rst;
  logic       mv [4];
  logic [7:0] md [4];
  logic       mr [4];
  logic       sv [4];
  logic [7:0] sd [4];
  logic       sr [4];
  logic [1:0] occ0;
  logic [2:0] occ1;
  logic [2:0] occ2;
  logic [1:0] occ3;
  logic [3:0] occ_x [4];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  assign occ_x[0] = {2'b00, occ0};
  assign occ_x[1] = {1'b0, occ1};
  assign occ_x[2] = {1'b0, occ2};
  assign occ_x[3] = {2'b00, occ3};

  handshake_reg_slice #(.WIDTH(8), .MODE(0), .STAGES(1)) u_byp (
    .clk(clk), .rst(rst), .m_valid(mv[0]), .m_data(md[0]), .m_ready(mr[0]),
    .s_valid(sv[0]), .s_data(sd[0]), .s_ready(sr[0]), .occ(occ0));
  handshake_reg_slice #(.WIDTH(8), .MODE(1), .STAGES(3)) u_fwd (
    .clk(clk), .rst(rst), .m_valid(mv[1]), .m_data(md[1]), .m_ready(mr[1]),
    .s_valid(sv[1]), .s_data(sd[1]), .s_ready(sr[1]), .occ(occ1));
  handshake_reg_slice #(.WIDTH(8), .MODE(2), .STAGES(2)) u_skd (
    .clk(clk), .rst(rst), .m_valid(mv[2]), .m_data(md[2]), .m_ready(mr[2]),
    .s_valid(sv[2]), .s_data(sd[2]), .s_ready(sr[2]), .occ(occ2));
  handshake_reg_slice #(.WIDTH(8), .MODE(3), .STAGES(1)) u_ful (
    .clk(clk), .rst(rst), .m_valid(mv[3]), .m_data(md[3]), .m_ready(mr[3]),
    .s_valid(sv[3]), .s_data(sd[3]), .s_ready(sr[3]), .occ(occ3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b1;
      md[i] = 8'h99;
      sr[i] = 1'b0;
    end
    sr[0] = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (sv[i] !== 1'b0) begin errors++; $display("FAIL rst_s_valid[%0d]: got %b want 0", i, sv[i]); end
      checks++;
      if (mr[i] !== 1'b0) begin errors++; $display("FAIL rst_m_ready[%0d]: got %b want 0", i, mr[i]); end
      checks++;
      if (occ_x[i] !== 4'd0) begin errors++; $display("FAIL rst_occ[%0d]: got %0d want 0", i, occ_x[i]); end
    end
    checks++;
    if (sd[3] !== 8'h00) begin errors++; $display("FAIL rst_s_data_full: got %h want 00", sd[3]); end
    checks++;
    if (sd[1] !== 8'h00) begin errors++; $display("FAIL rst_s_data_fwd: got %h want 00", sd[1]); end
    checks++;
    if (mr[0] !== 1'b1 || sv[0] !== 1'b1 || sd[0] !== 8'h99) begin
      errors++; $display("FAIL rst_bypass: got mr=%b sv=%b sd=%h want 1 1 99", mr[0], sv[0], sd[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    #1;
    checks++;
    if (mr[1] !== 1'b1) begin errors++; $display("FAIL rel_fwd_ready: got %b want 1", mr[1]); end
    checks++;
    if (mr[2] !== 1'b0 || mr[3] !== 1'b0) begin errors++; $display("FAIL rel_early_ready: got %b %b want 0 0", mr[2], mr[3]); end
    @(negedge clk);
    #1;
    checks++;
    if (mr[2] !== 1'b1 || mr[3] !== 1'b1) begin errors++; $display("FAIL rel_edge_ready: got %b %b want 1 1", mr[2], mr[3]); end
  endtask

  task automatic test_bypass();
    logic [9:0] vec [4];
    vec[0] = {1'b1, 1'b0, 8'h5A};
    vec[1] = {1'b0, 1'b1, 8'hC3};
    vec[2] = {1'b1, 1'b1, 8'hFF};
    vec[3] = {1'b0, 1'b0, 8'h00};
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      mv[0] = vec[v][9];
      sr[0] = vec[v][8];
      md[0] = vec[v][7:0];
      #1;
      checks++;
      if (sv[0] !== vec[v][9] || sd[0] !== vec[v][7:0] || mr[0] !== vec[v][8]) begin
        errors++;
        $display("FAIL bypass[%0d]: got sv=%b sd=%h mr=%b want %b %h %b", v, sv[0], sd[0], mr[0], vec[v][9], vec[v][7:0], vec[v][8]);
      end
    end
    sr[0] = 1'b0;
  endtask

  task automatic test_streaming();
    int n_in = 0;
    int n_out = 0;
    int c_in = -1;
    int c_out = -1;
    sr[3] = 1'b1;
    for (int c = 0; c < 40 && n_out < 16; c++) begin
      @(negedge clk);
      mv[3] = (n_in < 16);
      md[3] = 8'(n_in + 1);
      #1;
      checks++;
      if (occ_x[3] > 4'd1) begin errors++; $display("FAIL stream_occ: got %0d want <=1", occ_x[3]); end
      if (sv[3] && sr[3]) begin
        checks++;
        if (sd[3] !== 8'(n_out + 1)) begin errors++; $display("FAIL stream_data: got %h want %h", sd[3], 8'(n_out + 1)); end
        if (c_out < 0) c_out = c;
        n_out++;
      end
      if (mv[3] && mr[3]) begin
        if (c_in < 0) c_in = c;
        n_in++;
      end
    end
    mv[3] = 1'b0;
    checks++;
    if (n_out != 16) begin errors++; $display("FAIL stream_count: got %0d want 16", n_out); end
    checks++;
    if (c_out - c_in != 1) begin errors++; $display("FAIL stream_latency: got %0d want 1", c_out - c_in); end
  endtask

  task automatic test_backpressure();
    int n_in = 0;
    int n_out = 0;
    for (int c = 0; c < 10 && n_out < 3; c++) begin
      @(negedge clk);
      sr[3] = (c >= 3);
      mv[3] = (n_in < 3);
      md[3] = 8'hA0 + 8'(n_in);
      #1;
      if (c == 2) begin
        checks++;
        if (mr[3] !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", mr[3]); end
        checks++;
        if (occ_x[3] !== 4'd2) begin errors++; $display("FAIL bp_occ: got %0d want 2", occ_x[3]); end
        checks++;
        if (n_in != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", n_in); end
      end
      if (sv[3] && sr[3]) begin
        checks++;
        if (sd[3] !== 8'hA0 + 8'(n_out) || c != 3 + n_out) begin
          errors++; $display("FAIL bp_out: got %h at cycle %0d want %h at cycle %0d", sd[3], c, 8'hA0 + 8'(n_out), 3 + n_out);
        end
        n_out++;
      end
      if (mv[3] && mr[3]) n_in++;
    end
    mv[3] = 1'b0;
    checks++;
    if (n_out != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", n_out); end
  endtask

  task automatic test_skid();
    int n_in = 0;
    int n_out = 0;
    logic stall = 1'b0;
    logic [7:0] held = 8'h00;
    logic r0;
    for (int c = 0; c < 200 && n_out < 32; c++) begin
      @(negedge clk);
      sr[2] = c[0];
      mv[2] = (n_in < 32);
      md[2] = 8'h40 + 8'(n_in);
      #1;
      if (stall) begin
        checks++;
        if (sv[2] !== 1'b1 || sd[2] !== held) begin errors++; $display("FAIL skid_hold: got sv=%b sd=%h want 1 %h", sv[2], sd[2], held); end
      end
      if (sv[2] && sr[2]) begin
        checks++;
        if (sd[2] !== 8'h40 + 8'(n_out)) begin errors++; $display("FAIL skid_data: got %h want %h", sd[2], 8'h40 + 8'(n_out)); end
        n_out++;
      end
      if (mv[2] && mr[2]) n_in++;
      stall = sv[2] & ~sr[2];
      held  = sd[2];
      r0 = mr[2];
      sr[2] = ~sr[2];
      #1;
      checks++;
      if (mr[2] !== r0) begin errors++; $display("FAIL skid_ready_comb: got %b want %b", mr[2], r0); end
      sr[2] = ~sr[2];
      #1;
    end
    mv[2] = 1'b0;
    sr[2] = 1'b0;
    checks++;
    if (n_out != 32 || n_in != 32) begin errors++; $display("FAIL skid_count: got in=%0d out=%0d want 32 32", n_in, n_out); end
  endtask

  task automatic test_forward();
    int n_in = 0;
    int n_out = 0;
    sr[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mv[1] = 1'b1;
      md[1] = 8'h70 + 8'(n_in);
      #1;
      checks++;
      if (mr[1] !== (c < 3)) begin errors++; $display("FAIL fwd_ready[%0d]: got %b want %b", c, mr[1], (c < 3)); end
      if (c == 3) begin
        checks++;
        if (occ_x[1] !== 4'd3) begin errors++; $display("FAIL fwd_occ: got %0d want 3", occ_x[1]); end
      end
      if (mv[1] && mr[1]) n_in++;
    end
    checks++;
    if (n_in != 3) begin errors++; $display("FAIL fwd_accepted: got %0d want 3", n_in); end
    for (int c = 0; c < 10 && n_out < 3; c++) begin
      @(negedge clk);
      mv[1] = 1'b0;
      sr[1] = 1'b1;
      #1;
      if (sv[1] && sr[1]) begin
        checks++;
        if (sd[1] !== 8'h70 + 8'(n_out)) begin errors++; $display("FAIL fwd_data: got %h want %h", sd[1], 8'h70 + 8'(n_out)); end
        n_out++;
      end
    end
    sr[1] = 1'b0;
    checks++;
    if (n_out != 3) begin errors++; $display("FAIL fwd_drain: got %0d want 3", n_out); end
  endtask

  task automatic test_reset_mid();
    sr[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mv[3] = 1'b1;
      md[3] = 8'hB0 + 8'(c);
    end
    #1;
    checks++;
    if (occ_x[3] !== 4'd2 || mr[3] !== 1'b0) begin errors++; $display("FAIL mid_pre: got occ=%0d mr=%b want 2 0", occ_x[3], mr[3]); end
    rst = 1'b1;
    #1;
    checks++;
    if (sv[3] !== 1'b0 || mr[3] !== 1'b0 || occ_x[3] !== 4'd0) begin
      errors++; $display("FAIL mid_async: got sv=%b mr=%b occ=%0d want 0 0 0", sv[3], mr[3], occ_x[3]);
    end
    mv[3] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sv[3] !== 1'b0 || mr[3] !== 1'b0) begin errors++; $display("FAIL mid_release: got sv=%b mr=%b want 0 0", sv[3], mr[3]); end
    @(negedge clk);
    #1;
    checks++;
    if (mr[3] !== 1'b1 || sv[3] !== 1'b0 || occ_x[3] !== 4'd0) begin
      errors++; $display("FAIL mid_edge: got mr=%b sv=%b occ=%0d want 1 0 0", mr[3], sv[3], occ_x[3]);
    end
  endtask

  task automatic test_random(input int i, input int cycles);
    logic [7:0] seq = 8'h00;
    logic [7:0] held = 8'h00;
    logic [7:0] exp;
    logic stall = 1'b0;
    logic took = 1'b1;
    exp_q.delete();
    mv[i] = 1'b0;
    sr[i] = 1'b0;
    for (int c = 0; c < cycles + 30; c++) begin
      @(negedge clk);
      if (c < cycles) begin
        if (took || !mv[i]) begin
          mv[i] = ($urandom_range(0, 3) != 0);
          md[i] = seq;
        end
        sr[i] = ($urandom_range(0, 3) != 0);
      end else begin
        if (took) mv[i] = 1'b0;
        sr[i] = 1'b1;
      end
      #1;
      checks++;
      if (occ_x[i] !== 4'(exp_q.size())) begin errors++; $display("FAIL rnd%0d_occ: got %0d want %0d", i, occ_x[i], exp_q.size()); end
      if (stall) begin
        checks++;
        if (sv[i] !== 1'b1 || sd[i] !== held) begin errors++; $display("FAIL rnd%0d_hold: got sv=%b sd=%h want 1 %h", i, sv[i], sd[i], held); end
      end
      took = mv[i] & mr[i];
      if (took) begin
        exp_q.push_back(md[i]);
        seq = seq + 8'd1;
      end
      if (sv[i] && sr[i]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd%0d_extra: got beat %h want none", i, sd[i]);
        end else begin
          exp = exp_q.pop_front();
          if (sd[i] !== exp) begin errors++; $display("FAIL rnd%0d_data: got %h want %h", i, sd[i], exp); end
        end
      end
      stall = sv[i] & ~sr[i];
      held  = sd[i];
    end
    mv[i] = 1'b0;
    sr[i] = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rnd%0d_lost: got %0d beats left want 0", i, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_streaming();
    test_backpressure();
    test_skid();
    test_forward();
    test_reset_mid();
    for (int i = 0; i < 4; i++) test_random(i, 2500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handshake_reg_slice.md
# handshake_reg_slice

- Parametrised valid/ready pipeline slice with four modes: bypass, forward-registered, backward-registered (skid) and fully-registered.
- Up to `STAGES` slices can be cascaded inside one instance.
- Sits on any point-to-point handshake channel where timing closure needs a register on the data/valid path, the ready path, or both.
- Loses no beats, duplicates no beats, and sustains one beat per cycle in every mode.

## Interface
- `WIDTH`, 8: payload width in bits, ≥1.
- `MODE`, 3:
  - 0 = bypass.
  - 1 = forward (valid/data registered).
  - 2 = backward (ready registered, skid).
  - 3 = full (all outputs registered).
- `STAGES`, 1: number of cascaded slices, 1–4. Ignored in MODE 0.
- `OCCW`, `$clog2(2*STAGES+1)`: occupancy width. Derived; do not override.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `m_valid`, input, 1: upstream beat valid.
- `m_data`, input, WIDTH: upstream payload.
- `m_ready`, output, 1: slice accepts a beat this cycle.
- `s_valid`, output, 1: downstream beat valid.
- `s_data`, output, WIDTH: downstream payload.
- `s_ready`, input, 1: downstream accepts a beat.
- `occ`, output, OCCW: beats currently held across all stages. Always 0 in MODE 0.

## Operation
- **Handshake rules**
  - A beat transfers on a side when valid and ready are both high at a rising edge.
  - Once `s_valid` rises, `s_valid` and `s_data` hold until accepted.
  - Payload registers load only on an accepted beat, never on `m_valid` alone.
- **MODE 0**
  - `s_valid = m_valid`, `s_data = m_data`, `m_ready = s_ready`, all combinational.
  - No state. `occ = 0`.
- **MODE 1, per stage**
  - One data register plus a valid flag. Capacity 1.
  - `m_ready = ~s_valid | s_ready`, combinational through all stages.
  - On accept: register loads `m_data` and the flag sets.
  - If the stage's output is accepted with no new accept, the flag clears.
- **MODE 2, per stage**
  - States PASS (skid empty) and SKID (skid holds a beat). Capacity 1.
  - `m_ready` is registered: 1 in PASS, 0 in SKID.
  - `s_valid = m_valid | skid_full`.
  - `s_data = skid_full ? skid : m_data`.
  - PASS→SKID on `m_valid & m_ready & ~s_ready`; skid loads `m_data`.
  - SKID→PASS on `s_ready`.
- **MODE 3, per stage**
  - States EMPTY, BUSY and FULL; a main register plus a skid register. Capacity 2.
  - `s_valid` and `m_ready` are both registered: `s_valid = (state != EMPTY)`, `m_ready = (state != FULL)`.
  - EMPTY→BUSY on `m_valid`; main loads.
  - In BUSY:
    - `m_valid & s_ready`: stay in BUSY; main loads the new beat.
    - `m_valid & ~s_ready` → FULL; skid loads.
    - `~m_valid & s_ready` → EMPTY.
    - Otherwise hold.
  - FULL→BUSY on `s_ready`; main loads from skid. No upstream accept is possible in FULL.
- **Occupancy**
  - `occ` is the sum of per-stage valid/skid flags, registered.
  - Range: 0..STAGES in MODE 1/2, 0..2·STAGES in MODE 3.
  - It changes only by −1, 0 or +1 per cycle.
- **Simultaneous accept in and out:** occupancy is unchanged and ordering is preserved (FIFO order, never reordered).

## Timing
- **Reset values, asynchronous, applied while `rst` = 1**
  - `s_valid` = 0, `s_data` = 0, `occ` = 0.
  - All states EMPTY/PASS.
  - `m_ready` = 0 in MODE 1/2/3; MODE 1 gates it combinationally with `~rst`.
  - MODE 0 outputs follow inputs even during reset.
- **After `rst` falls**
  - MODE 2/3: `m_ready` rises at the first rising edge.
  - MODE 1: `m_ready` is 1 immediately.
- **Latency, m-accept to `s_valid`**
  - MODE 0 and 2: 0 cycles per stage.
  - MODE 1 and 3: 1 cycle per stage.
- **Throughput:** 1 beat/cycle in all modes while `s_ready` = 1.
- **Backpressure (`s_ready` low)**
  - MODE 3 absorbs exactly 2 more beats per stage before `m_ready` falls.
  - MODE 2 absorbs 1 per stage.
  - `m_ready` falls the cycle after the last absorb in MODE 2/3, and in the same cycle in MODE 1.
- **Reset mid-operation:** held beats are discarded; `occ` returns to 0 with no glitch on `s_valid` after release.

## Test plan
- **Streaming:** MODE 3, STAGES=1, `s_ready` = 1, send 0x01..0x10 back-to-back.
  - 16 beats out in order.
  - First `s_valid` 1 cycle after first accept.
  - `occ` ≤ 1 throughout.
- **Backpressure:** MODE 3, `s_ready` = 0, stream 0xA0, 0xA1, 0xA2.
  - 0xA0 and 0xA1 accepted, then `m_ready` = 0 and `occ` = 2.
  - Raise `s_ready`: outputs 0xA0, 0xA1, 0xA2 in order with no gaps.
- **Skid:** MODE 2, STAGES=2, toggle `s_ready` every cycle while streaming 32 beats.
  - No loss, no duplicate.
  - `s_data` stable whenever `s_valid & ~s_ready`.
  - `m_ready` never depends combinationally on `s_ready` (checked by assertion).
- **Forward:** MODE 1, STAGES=3, hold `m_valid` = 1 with `s_ready` = 0.
  - Exactly 3 beats accepted; `occ` = 3.
  - `m_ready` = 0 in the same cycle the third stage fills.
- **Reset:** assert `rst` mid-burst with `occ` = 2 (MODE 3).
  - `s_valid` = 0, `m_ready` = 0 and `occ` = 0 immediately, without waiting for a clock edge.
  - `m_ready` = 1 at the first edge after release.
- **Bypass and random:** MODE 0.
  - `s_valid`/`s_data`/`m_ready` equal `m_valid`/`m_data`/`s_ready` in the same cycle.
  - Randomised valid/ready for 10k cycles in all modes against a scoreboard: zero mismatches.
